// File: rtl/fc_accumulator.sv
// fc_accumulator
//   Sums signed partial products over a programmed input length, one total
//   per output neuron. Each total is shifted right arithmetically by SHIFT
//   and clamped to DATA_WIDTH bits. It then goes out as a one-cycle pulse on
//   the acc_valid/acc_last/acc_result interface. One start_i runs a whole
//   layer of neuron_cnt_i neurons.
//
//   Optional feature macro: FC_ACC_BIAS_EN
//     defined   - each neuron's accumulator starts from bias_i
//     undefined - each neuron's accumulator starts from zero; bias_i ignored
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   start_i       layer start, honoured only in IDLE
//   in_len_i      partial products per neuron (latched on accepted start)
//   neuron_cnt_i  neurons per layer (latched on accepted start)
//   psum_valid_i  partial product valid
//   psum_i        signed partial product
//   bias_i        signed initial accumulator value (FC_ACC_BIAS_EN only)
//   psum_ready_o  high in ACCUM; a partial product is taken on valid && ready
//   busy_o        high whenever not IDLE
//   acc_valid_o   one-cycle result pulse per neuron
//   acc_last_o    marks the layer's final neuron, together with acc_valid_o
//   acc_result_o  signed requantised result, holds between pulses
module fc_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN_WIDTH  = 10,
    parameter int SHIFT      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  in_len_i,
    input  logic [LEN_WIDTH-1:0]  neuron_cnt_i,
    input  logic                  psum_valid_i,
    input  logic [PSUM_WIDTH-1:0] psum_i,
    input  logic [ACC_WIDTH-1:0]  bias_i,
    output logic                  psum_ready_o,
    output logic                  busy_o,
    output logic                  acc_valid_o,
    output logic                  acc_last_o,
    output logic [DATA_WIDTH-1:0] acc_result_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Clamp a one-bit-wider sum back into the accumulator range.
    function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] s);
        logic [ACC_WIDTH-1:0] r;
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            r = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Arithmetic shift (floor) followed by clamp into the signed output range.
    function automatic logic [DATA_WIDTH-1:0] sat_d(input logic [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0]   shifted;
        logic [ACC_WIDTH-DATA_WIDTH:0] upper;
        logic [DATA_WIDTH-1:0]         r;
        shifted = $signed(v) >>> SHIFT;
        upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
        // Fits when every bit above the output sign bit repeats that sign bit.
        if ((&upper) || (~|upper)) begin
            r = shifted[DATA_WIDTH-1:0];
        end else if (shifted[ACC_WIDTH-1]) begin
            r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    state_t                state_r, state_s;
    logic [ACC_WIDTH-1:0]  acc_r, acc_s;
    logic [LEN_WIDTH-1:0]  elem_cnt_r, elem_cnt_s;
    logic [LEN_WIDTH-1:0]  neuron_idx_r, neuron_idx_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [LEN_WIDTH-1:0]  cnt_r, cnt_s;
    logic                  valid_r, valid_s;
    logic                  last_r, last_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;
    logic [ACC_WIDTH-1:0]  init_s;
    logic [ACC_WIDTH-1:0]  sum_s;

`ifdef FC_ACC_BIAS_EN
    assign init_s = bias_i;
`else
    assign init_s = {ACC_WIDTH{1'b0}};
`endif

    // Saturating sum of the running total and the sign-extended partial product.
    assign sum_s = sat_acc({acc_r[ACC_WIDTH-1], acc_r}
                         + {{(ACC_WIDTH+1-PSUM_WIDTH){psum_i[PSUM_WIDTH-1]}}, psum_i});

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        acc_s        = acc_r;
        elem_cnt_s   = elem_cnt_r;
        neuron_idx_s = neuron_idx_r;
        len_s        = len_r;
        cnt_s        = cnt_r;
        valid_s      = 1'b0;
        last_s       = 1'b0;
        result_s     = result_r;
        case (state_r)
            IDLE: begin
                if (start_i && (in_len_i != {LEN_WIDTH{1'b0}})
                            && (neuron_cnt_i != {LEN_WIDTH{1'b0}})) begin
                    len_s        = in_len_i;
                    cnt_s        = neuron_cnt_i;
                    elem_cnt_s   = {LEN_WIDTH{1'b0}};
                    neuron_idx_s = {LEN_WIDTH{1'b0}};
                    acc_s        = init_s;
                    state_s      = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (psum_valid_i) begin
                    acc_s      = sum_s;
                    elem_cnt_s = elem_cnt_r + LEN_WIDTH'(1);
                    // The result and last flag are registered on the final
                    // acceptance so they appear during the EMIT cycle itself.
                    if (elem_cnt_r == len_r - LEN_WIDTH'(1)) begin
                        state_s  = EMIT;
                        valid_s  = 1'b1;
                        last_s   = (neuron_idx_r == cnt_r - LEN_WIDTH'(1));
                        result_s = sat_d(sum_s);
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            EMIT: begin
                if (last_r) begin
                    state_s = IDLE;
                end else begin
                    neuron_idx_s = neuron_idx_r + LEN_WIDTH'(1);
                    elem_cnt_s   = {LEN_WIDTH{1'b0}};
                    acc_s        = init_s;
                    state_s      = ACCUM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_WIDTH{1'b0}};
            elem_cnt_r   <= {LEN_WIDTH{1'b0}};
            neuron_idx_r <= {LEN_WIDTH{1'b0}};
            len_r        <= {LEN_WIDTH{1'b0}};
            cnt_r        <= {LEN_WIDTH{1'b0}};
            valid_r      <= 1'b0;
            last_r       <= 1'b0;
            result_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            elem_cnt_r   <= elem_cnt_s;
            neuron_idx_r <= neuron_idx_s;
            len_r        <= len_s;
            cnt_r        <= cnt_s;
            valid_r      <= valid_s;
            last_r       <= last_s;
            result_r     <= result_s;
        end
    end

    assign psum_ready_o = (state_r == ACCUM);
    assign busy_o       = (state_r != IDLE);
    assign acc_valid_o  = valid_r;
    assign acc_last_o   = last_r;
    assign acc_result_o = result_r;

endmodule

// File: tb/tb_fc_accumulator.sv
module tb_fc_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [9:0]  in_len_i;
    logic [9:0]  neuron_cnt_i;
    logic        psum_valid_i;
    logic [15:0] psum_i;
    logic [23:0] bias_i;
    logic        psum_ready_o;
    logic        busy_o;
    logic        acc_valid_o;
    logic        acc_last_o;
    logic [7:0]  acc_result_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pulses_base;

    fc_accumulator #(
        .DATA_WIDTH(8), .PSUM_WIDTH(16), .ACC_WIDTH(24), .LEN_WIDTH(10), .SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .in_len_i(in_len_i),
        .neuron_cnt_i(neuron_cnt_i), .psum_valid_i(psum_valid_i), .psum_i(psum_i),
        .bias_i(bias_i), .psum_ready_o(psum_ready_o), .busy_o(busy_o),
        .acc_valid_o(acc_valid_o), .acc_last_o(acc_last_o), .acc_result_o(acc_result_o)
    );

    always #5 clk = ~clk;

    // Count result pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (acc_valid_o) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_layer(input logic [9:0] len, input logic [9:0] cnt);
        start_i = 1'b1; in_len_i = len; neuron_cnt_i = cnt;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        int n;
        n = 0;
        while (!psum_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("feed_ready", 32'(psum_ready_o), 32'h1);
        psum_valid_i = 1'b1; psum_i = v;
        @(negedge clk);
        psum_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; in_len_i = '0; neuron_cnt_i = '0;
        psum_valid_i = 1'b0; psum_i = '0; bias_i = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 32'(acc_valid_o), 32'h0);
        chk("rst_last", 32'(acc_last_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(psum_ready_o), 32'h0);
        chk("rst_result", 32'(acc_result_o), 32'h0);
        rst = 1'b0;

        // zero-length and zero-count starts are ignored
        start_layer(10'd0, 10'd1);
        chk("zero_len_idle", 32'(busy_o), 32'h0);
        start_layer(10'd1, 10'd0);
        chk("zero_cnt_idle", 32'(busy_o), 32'h0);

        // single neuron: 100 >>> 2 = 25
        start_layer(10'd4, 10'd1);
        chk("start_ready", 32'(psum_ready_o), 32'h1);
        feed(16'd10); feed(16'd20); feed(16'd30); feed(16'd40);
        chk("single_valid", 32'(acc_valid_o), 32'h1);
        chk("single_last", 32'(acc_last_o), 32'h1);
        chk("single_result", 32'(acc_result_o), 32'h19);
        chk("single_emit_ready", 32'(psum_ready_o), 32'h0);
        @(negedge clk);
        chk("single_valid_drop", 32'(acc_valid_o), 32'h0);
        chk("single_busy_drop", 32'(busy_o), 32'h0);
        chk("single_hold", 32'(acc_result_o), 32'h19);
        chk("single_pulses", 32'(pulses), 32'd1);

        // -6 >>> 2 = -2
        start_layer(10'd2, 10'd1);
        feed(16'hFFFD); feed(16'hFFFD);
        chk("neg_valid", 32'(acc_valid_o), 32'h1);
        chk("neg_result", 32'(acc_result_o), 32'hFE);
        @(negedge clk);
        // 1000 >>> 2 = 250 -> +127
        start_layer(10'd1, 10'd1);
        feed(16'd1000);
        chk("satpos_result", 32'(acc_result_o), 32'h7F);
        chk("satpos_last", 32'(acc_last_o), 32'h1);
        @(negedge clk);
        // -1000 >>> 2 = -250 -> -128
        start_layer(10'd1, 10'd1);
        feed(16'hFC18);
        chk("satneg_result", 32'(acc_result_o), 32'h80);
        @(negedge clk);
        chk("sat_pulses", 32'(pulses), 32'd4);

        // three neurons, len 2, gaps, valid held high in EMIT with 100
        start_layer(10'd2, 10'd3);
        feed(16'd5); @(negedge clk); feed(16'd7);          // 12 -> 3
        chk("n0_valid", 32'(acc_valid_o), 32'h1);
        chk("n0_result", 32'(acc_result_o), 32'h03);
        chk("n0_last", 32'(acc_last_o), 32'h0);
        psum_valid_i = 1'b1; psum_i = 16'd100;
        @(negedge clk);
        psum_valid_i = 1'b0;
        feed(16'd40); @(negedge clk); @(negedge clk); feed(16'd4);  // 44 -> 11
        chk("n1_valid", 32'(acc_valid_o), 32'h1);
        chk("n1_result", 32'(acc_result_o), 32'h0B);
        chk("n1_last", 32'(acc_last_o), 32'h0);
        psum_valid_i = 1'b1; psum_i = 16'd100;
        @(negedge clk);
        psum_valid_i = 1'b0;
        feed(16'hFFF8); feed(16'hFFF7);                     // -17 -> -5
        chk("n2_valid", 32'(acc_valid_o), 32'h1);
        chk("n2_result", 32'(acc_result_o), 32'hFB);
        chk("n2_last", 32'(acc_last_o), 32'h1);
        @(negedge clk);
        chk("multi_busy_drop", 32'(busy_o), 32'h0);
        chk("multi_pulses", 32'(pulses), 32'd7);

        // reset mid-accumulation discards the neuron
        start_layer(10'd4, 10'd1);
        feed(16'd50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_ready", 32'(psum_ready_o), 32'h0);
        chk("midrst_result", 32'(acc_result_o), 32'h0);
        pulses_base = pulses;
        @(negedge clk); @(negedge clk);
        chk("midrst_no_pulse", 32'(pulses), 32'(pulses_base));
        start_layer(10'd4, 10'd1);
        feed(16'd10); feed(16'd20); feed(16'd30); feed(16'd40);
        chk("after_rst_result", 32'(acc_result_o), 32'h19);
        @(negedge clk);

        // bias of 8: 108 >>> 2 = 27 when enabled, else ignored
        bias_i = 24'd8;
        start_layer(10'd4, 10'd1);
        feed(16'd10); feed(16'd20); feed(16'd30); feed(16'd40);
`ifdef FC_ACC_BIAS_EN
        chk("bias_result", 32'(acc_result_o), 32'h1B);
`else
        chk("bias_result", 32'(acc_result_o), 32'h19);
`endif
        @(negedge clk);
        bias_i = 24'd0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
